fetch_decode_pipe_reg: RTL and testbench
========================================

// Module: fetch_decode_pipe_reg
// PURPOSE
//  Parametrised IF/ID pipeline register for the 5-stage RISC-V core. Carries PC and
//  instruction from fetch to decode under a valid/ready handshake. Supports a 2-entry
//  skid mode (full throughput, registered in_ready) and a 1-entry mode.
//  Adds a synchronous flush for branch/jump redirect. Inserts NOP bubbles when empty.
// PARAMETERS
//  XLEN      32            width of PC field
//  ILEN      32            width of instruction field
//  SKID_EN   1             1: 2-entry skid buffer; 0: single entry, in_ready combinational
//  NOP_INSTR 32'h00000013  bubble encoding (addi x0,x0,0), width ILEN
// PORTS
//  clock      in   1     rising-edge clock
//  reset      in   1     asynchronous, active-low reset
//  flush      in   1     sync flush: discard all held entries this cycle
//  in_valid   in   1     fetch presents a PC/instruction pair
//  in_ready   out  1     register can accept this cycle
//  in_pc      in   XLEN  fetch PC
//  in_instr   in   ILEN  fetched instruction
//  out_valid  out  1     decode-side entry valid
//  out_ready  in   1     decode consumes (low = hazard stall)
//  out_pc     out  XLEN  PC to decode
//  out_instr  out  ILEN  instruction to decode; NOP_INSTR when !out_valid
//  occupancy  out  2     entries held (0..2; max 1 when SKID_EN=0)
// BEHAVIOUR
//  - Reset (reset=0, async): state EMPTY, out_valid=0, out_pc=0, out_instr=NOP_INSTR,
//    occupancy=0, in_ready=1. Skid slot cleared to pc=0/NOP. Takes effect without clock.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Latency: accepted beat appears on out_* the cycle after in_fire (1 cycle).
//  - All outputs are registered except in_ready when SKID_EN=0.
//  - SKID_EN=1 states (main slot drives out_*, skid slot hidden):
//      EMPTY: in_fire -> ONE (main<=in).
//      ONE:   in_fire&!out_fire -> FULL (skid<=in); in_fire&out_fire -> ONE (main<=in);
//             !in_fire&out_fire -> EMPTY (main<=pc 0/NOP); else hold.
//      FULL:  out_fire -> ONE (main<=skid, skid<=0/NOP); else hold.
//      in_ready = (state!=FULL), registered.
//  - SKID_EN=0: states EMPTY/ONE only; in_ready = !out_valid | out_ready;
//    in_fire&out_fire -> ONE with new data; FULL unreachable.
//  - Ordering strictly FIFO; no beat duplicated or dropped except by flush.
//  - flush=1: next state EMPTY, both slots cleared to pc 0/NOP, regardless of in_fire,
//    out_fire or out_ready in that cycle; a beat accepted in the flush cycle is
//    discarded. flush has priority over every other transition.
//  - out_ready=0 (stall): out_pc/out_instr stable while out_valid=1.
//  - Reset asserted mid-transfer: all held beats lost, outputs as reset values.
//  - occupancy = 0/1/2 for EMPTY/ONE/FULL, updated with state.
// STRUCTURE
//  - Shared package rv_pipe_pkg: NOP_INSTR constant, pipe-register state encoding
//    (EMPTY=2'd0, ONE=2'd1, FULL=2'd2), XLEN/ILEN defaults reused by ID/EX, EX/MEM regs.
//  - Sub-module pipe_slot: one PC/instr pair with load/clear, async active-low reset
//    to 0/NOP; instantiated as main and (if SKID_EN) skid slot.
//  - Control FSM and in_ready logic inline in this module.
// TESTING
//  1. Reset then release, no traffic -> out_valid=0, out_instr=32'h00000013, in_ready=1.
//  2. Stream pc 0x0,0x4,0x8 with out_ready=1 -> same pc/instr on out_* 1 cycle later,
//     back-to-back, occupancy=1, in_ready stays 1.
//  3. SKID_EN=1, out_ready=0 while sending 0x0,0x4,0x8 -> 0x0 held, 0x4 in skid,
//     occupancy=2, in_ready=0, 0x8 not accepted; raise out_ready -> 0x0,0x4,0x8 in order.
//  4. Flush with occupancy=2 and in_valid=1 (pc 0x20) -> next cycle out_valid=0,
//     out_instr=NOP, occupancy=0; pc 0x20 never appears.
//  5. SKID_EN=0, out_ready toggling each cycle -> in_ready=out_ready when full,
//     no loss/duplication over 100 random beats (scoreboard).
//  6. Assert reset async mid-stream between edges -> outputs reach reset values
//     before next clock edge.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the core's pipeline registers (IF/ID, ID/EX, EX/MEM).
package rv_pipe_pkg;

  localparam int unsigned RV_XLEN = 32;
  localparam int unsigned RV_ILEN = 32;
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One PC/instruction storage slot; clear wins over load, resets to pc 0 / NOP.
module pipe_slot #(
  parameter int unsigned     XLEN      = rv_pipe_pkg::RV_XLEN,
  parameter int unsigned     ILEN      = rv_pipe_pkg::RV_ILEN,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(rv_pipe_pkg::RV_NOP_INSTR)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] d_pc,
  input  logic [ILEN-1:0] d_instr,
  output logic [XLEN-1:0] q_pc,
  output logic [ILEN-1:0] q_instr
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_pc    <= '0;
      q_instr <= NOP_INSTR;
    end else if (clear) begin
      q_pc    <= '0;
      q_instr <= NOP_INSTR;
    end else if (load) begin
      q_pc    <= d_pc;
      q_instr <= d_instr;
    end
  end

endmodule

// File: rtl/fetch_decode_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshake, optional 2-entry skid, sync flush.
module fetch_decode_pipe_reg #(
  parameter int unsigned     XLEN      = rv_pipe_pkg::RV_XLEN,
  parameter int unsigned     ILEN      = rv_pipe_pkg::RV_ILEN,
  parameter bit              SKID_EN   = 1'b1,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(rv_pipe_pkg::RV_NOP_INSTR)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic [1:0]      occupancy
);
  import rv_pipe_pkg::*;

  pipe_state_e     state, state_nxt;
  logic            in_fire, out_fire;
  logic            main_load, main_clear, main_from_skid;
  logic            skid_load, skid_clear;
  logic [XLEN-1:0] skid_pc, main_d_pc;
  logic [ILEN-1:0] skid_instr, main_d_instr;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = (state != PIPE_EMPTY);
  assign occupancy = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= PIPE_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_nxt  = PIPE_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        PIPE_EMPTY: begin
          if (in_fire) begin
            state_nxt = PIPE_ONE;
            main_load = 1'b1;
          end
        end
        PIPE_ONE: begin
          // Without a skid slot in_ready implies out_fire here, so FULL is never entered.
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire && SKID_EN) begin
            state_nxt = PIPE_FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_nxt  = PIPE_EMPTY;
            main_clear = 1'b1;
          end
        end
        PIPE_FULL: begin
          if (out_fire) begin
            state_nxt      = PIPE_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_nxt  = PIPE_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_d_pc    = main_from_skid ? skid_pc    : in_pc;
  assign main_d_instr = main_from_skid ? skid_instr : in_instr;

  pipe_slot #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INSTR(NOP_INSTR)) u_main (
    .clock   (clock),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_pc    (main_d_pc),
    .d_instr (main_d_instr),
    .q_pc    (out_pc),
    .q_instr (out_instr)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic in_ready_q;

      pipe_slot #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_pc    (in_pc),
        .d_instr (in_instr),
        .q_pc    (skid_pc),
        .q_instr (skid_instr)
      );

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) in_ready_q <= 1'b1;
        else        in_ready_q <= (state_nxt != PIPE_FULL);
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_pc    = '0;
      assign skid_instr = NOP_INSTR;
      assign in_ready   = !out_valid | out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_fetch_decode_pipe_reg.sv
// Scoreboard bench: skid (SKID_EN=1) and single-entry (SKID_EN=0) instances share stimulus.
module tb_fetch_decode_pipe_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b0;

  logic        ir1, ov1, ir0, ov0;
  logic [31:0] pc1, ins1, pc0, ins0;
  logic [1:0]  occ1, occ0;

  beat_t       q1[$];
  beat_t       q0[$];
  logic        acc1 = 1'b1;
  logic        acc0 = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  fetch_decode_pipe_reg #(.XLEN(32), .ILEN(32), .SKID_EN(1'b1), .NOP_INSTR(NOP)) dut1 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(ov1), .out_ready(out_ready), .out_pc(pc1), .out_instr(ins1),
    .occupancy(occ1)
  );

  fetch_decode_pipe_reg #(.XLEN(32), .ILEN(32), .SKID_EN(1'b0), .NOP_INSTR(NOP)) dut0 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(ov0), .out_ready(out_ready), .out_pc(pc0), .out_instr(ins0),
    .occupancy(occ0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: 2 time units before each rising edge, compare against the reference FIFOs.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      // Reference acceptance rule: capacity 2 with skid, else 1 unless drained this cycle.
      acc1 = (q1.size() < 2);
      acc0 = (q0.size() == 0) || out_ready;
      chk("skid in_ready",  {31'b0, ir1},  {31'b0, acc1});
      chk("skid out_valid", {31'b0, ov1},  {31'b0, q1.size() != 0});
      chk("skid occupancy", {30'b0, occ1}, 32'(q1.size()));
      if (q1.size() != 0) begin
        chk("skid out_pc",    pc1,  q1[0].pc);
        chk("skid out_instr", ins1, q1[0].instr);
        if (out_ready) void'(q1.pop_front());
      end else begin
        chk("skid idle pc",    pc1,  32'h0);
        chk("skid idle instr", ins1, NOP);
      end
      chk("single in_ready",  {31'b0, ir0},  {31'b0, acc0});
      chk("single out_valid", {31'b0, ov0},  {31'b0, q0.size() != 0});
      chk("single occupancy", {30'b0, occ0}, 32'(q0.size()));
      if (q0.size() != 0) begin
        chk("single out_pc",    pc0,  q0[0].pc);
        chk("single out_instr", ins0, q0[0].instr);
        if (out_ready) void'(q0.pop_front());
      end else begin
        chk("single idle pc",    pc0,  32'h0);
        chk("single idle instr", ins0, NOP);
      end
    end
  end

  // Drive one cycle of stimulus and record what each instance should accept.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic fl, input logic ordy);
    @(negedge clock);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    flush     = fl;
    out_ready = ordy;
    #4;
    if (reset) begin
      if (fl) begin
        q1.delete();
        q0.delete();
      end else begin
        if (v && acc1) q1.push_back('{pc: pc, instr: ins});
        if (v && acc0) q0.push_back('{pc: pc, instr: ins});
      end
    end
  endtask

  logic [31:0] pc_ctr;

  initial begin
    // Test 1: reset, then idle
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Test 2: streaming with out_ready high
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 32'(i * 4), 32'h100 + 32'(i), 1'b0, 1'b1);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Test 3: stall while sending, then release
    pc_ctr = 32'h0;
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b1, pc_ctr, 32'h200 + pc_ctr, 1'b0, 1'b0);
      if (acc1) pc_ctr = pc_ctr + 32'h4;
    end
    for (int unsigned i = 0; i < 6; i++) begin
      step(pc_ctr <= 32'h8, pc_ctr, 32'h200 + pc_ctr, 1'b0, 1'b1);
      if (acc1 && pc_ctr <= 32'h8) pc_ctr = pc_ctr + 32'h4;
    end

    // Test 4: flush while full and presenting pc 0x20
    step(1'b1, 32'h10, 32'h310, 1'b0, 1'b0);
    step(1'b1, 32'h14, 32'h314, 1'b0, 1'b0);
    step(1'b1, 32'h20, 32'h320, 1'b1, 1'b0);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Test 5: out_ready toggling with random traffic
    for (int unsigned i = 0; i < 100; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'b0, 1'(i % 2));
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Fully random traffic with occasional flushes
    for (int unsigned i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));

    // Test 6: asynchronous reset between edges, mid-stream
    repeat (2) step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    q1.delete();
    q0.delete();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    for (int unsigned i = 0; i < 5; i++) step(1'b1, 32'h40 + 32'(i * 4), $urandom, 1'b0, 1'b1);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    @(negedge clock);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
